decode_ctrl_stage: RTL and testbench

//  Registered RV32I decode/control stage between fetch and execute. Decodes each 32-bit

---
 rtl/decode_ctrl_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode/control stage: decodes into a 17-bit control bundle held in a
// one-entry output register, with load-use interlock, FENCE serialisation and illegal flags.
module decode_ctrl_stage #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CSR_EN   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16:0]     out_ctrl,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal,
    input  logic            flush_i,
    input  logic            drain_i,
    output logic            stall_o
);

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

    localparam int unsigned CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StRun,
        StLoadStall,
        StFenceWait
    } state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [16:0]       out_ctrl_q;
    logic [31:0]       out_instr_q;
    logic [PC_W-1:0]   out_pc_q;
    logic              out_illegal_q;
    logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [4:0]        ld_rd_q, ld_rd_d;

    // ---------------------------------------------------------------- decode
    logic [6:0]  opcode;
    logic [1:0]  imm_sel, wr_sel;
    logic [2:0]  alu_op;
    logic        jump, branch, alu_src1, alu_src2, reg_write;
    logic        mem_read, mem_write, h_sel, csr, fence;
    logic        dec_illegal;
    logic [16:0] dec_ctrl;

    assign opcode = in_instr[6:0];

    always_comb begin
        imm_sel     = 2'b00;
        wr_sel      = 2'b00;
        alu_op      = 3'b000;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_src1    = 1'b0;
        alu_src2    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        h_sel       = 1'b0;
        csr         = 1'b0;
        fence       = 1'b0;
        dec_illegal = 1'b0;
        // Opcodes with [1:0] != 2'b11 never match a listed opcode and fall to default.
        case (opcode)
            OPC_LOAD: begin
                imm_sel   = 2'b01;
                alu_src2  = 1'b1;
                reg_write = 1'b1;
                mem_read  = 1'b1;
                wr_sel    = 2'b01;
                alu_op    = 3'b011;
            end
            OPC_STORE: begin
                imm_sel   = 2'b10;
                alu_src2  = 1'b1;
                mem_write = 1'b1;
                wr_sel    = 2'b01;
                alu_op    = 3'b010;
            end
            OPC_OP: begin
                reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_sel   = 2'b01;
                alu_src2  = 1'b1;
                reg_write = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_sel   = 2'b11;
                alu_src1  = 1'b1;
                alu_src2  = 1'b1;
                reg_write = 1'b1;
                alu_op    = 3'b001;
                wr_sel    = (opcode == OPC_LUI) ? 2'b10 : 2'b00;
            end
            OPC_JAL, OPC_JALR: begin
                imm_sel   = 2'b01;
                jump      = 1'b1;
                h_sel     = (opcode == OPC_JAL);
                alu_src2  = 1'b1;
                reg_write = 1'b1;
                wr_sel    = 2'b11;
                alu_op    = 3'b001;
            end
            OPC_BRANCH: begin
                branch = 1'b1;
                alu_op = 3'b101;
            end
            OPC_SYSTEM: begin
                if (CSR_EN != 0) begin
                    csr       = 1'b1;
                    alu_src2  = 1'b1;
                    reg_write = 1'b1;
                    wr_sel    = 2'b10;
                    alu_op    = 3'b100;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_MISCMEM: begin
                fence    = 1'b1;
                alu_src2 = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_ctrl = {fence, alu_op, wr_sel, csr, h_sel, mem_write, mem_read, reg_write,
                       alu_src2, alu_src1, branch, jump, imm_sel};

    // ---------------------------------------------------------------- load-use hazard
    logic       rs1_used, rs2_used;
    logic [4:0] rs1, rs2, out_rd;
    logic       out_is_load, pend_hit, out_hit, hazard;

    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign out_rd   = out_instr_q[11:7];
    assign rs1_used = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    // A pending load is either still in our output register or already handed to
    // execute and counting down its latency.
    assign out_is_load = out_valid_q && (out_instr_q[6:0] == OPC_LOAD);
    assign pend_hit    = (ld_cnt_q != '0) && (ld_rd_q != 5'd0) &&
                         ((rs1_used && (rs1 == ld_rd_q)) || (rs2_used && (rs2 == ld_rd_q)));
    assign out_hit     = out_is_load && (out_rd != 5'd0) &&
                         ((rs1_used && (rs1 == out_rd)) || (rs2_used && (rs2 == out_rd)));
    assign hazard      = (LOAD_LAT != 0) && in_valid && (pend_hit || out_hit);

    // ---------------------------------------------------------------- handshake
    logic in_xfer, out_xfer;

    assign in_ready = reset && (state_q == StRun) && !flush_i && !hazard &&
                      (!out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        ld_cnt_d    = ld_cnt_q;
        ld_rd_d     = ld_rd_q;

        unique case (state_q)
            StRun: begin
                if (hazard) begin
                    state_d = StLoadStall;
                end else if (in_xfer && fence) begin
                    state_d = StFenceWait;
                end
            end
            StLoadStall: begin
                if (!hazard) begin
                    state_d = StRun;
                end
            end
            StFenceWait: begin
                if (drain_i && !out_valid_q) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (in_xfer) begin
            out_valid_d = 1'b1;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (out_xfer && out_is_load) begin
            ld_rd_d  = out_rd;
            ld_cnt_d = CNT_LOAD;
        end else if (ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - CNT_ONE;
        end

        // Flush wins over a simultaneous output transfer; execute ignores that beat.
        if (flush_i) begin
            state_d     = StRun;
            out_valid_d = 1'b0;
            ld_cnt_d    = '0;
            ld_rd_d     = ld_rd_q;
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            out_valid_q   <= 1'b0;
            out_ctrl_q    <= '0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            out_illegal_q <= 1'b0;
            ld_cnt_q      <= '0;
            ld_rd_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ld_cnt_q    <= ld_cnt_d;
            ld_rd_q     <= ld_rd_d;
            if (in_xfer) begin
                out_ctrl_q    <= dec_ctrl;
                out_instr_q   <= in_instr;
                out_pc_q      <= in_pc;
                out_illegal_q <= dec_illegal;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_illegal = out_illegal_q;
    assign stall_o     = (state_q != StRun);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: two instances (LOAD_LAT=1/CSR_EN=1 and LOAD_LAT=0/CSR_EN=0)
// share stimulus and are compared every cycle against a behavioural model of the stage.
`timescale 1ns/1ps
module tb_decode_ctrl_stage;

    localparam logic [31:0] I_ADDI   = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_LW_X5  = 32'h00012283;  // lw   x5,0(x2)
    localparam logic [31:0] I_ADD    = 32'h00728333;  // add  x6,x5,x7
    localparam logic [31:0] I_LW_X0  = 32'h00012003;  // lw   x0,0(x2)
    localparam logic [31:0] I_ADD_X0 = 32'h00000333;  // add  x6,x0,x0
    localparam logic [31:0] I_FENCE  = 32'h0000000F;
    localparam logic [31:0] I_BAD    = 32'h0000007F;
    localparam logic [31:0] I_CSR    = 32'h30002373;  // csrrs x6,mstatus,x0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, out_ready, flush_i, drain_i;
    logic [31:0] in_instr, in_pc;
    logic        rdy [2];
    logic        vld [2];
    logic        ill [2];
    logic        stl [2];
    logic [16:0] ctrl [2];
    logic [31:0] oinstr [2];
    logic [31:0] opc [2];

    decode_ctrl_stage #(.PC_W(32), .LOAD_LAT(1), .CSR_EN(1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld[0]), .out_ready(out_ready),
        .out_ctrl(ctrl[0]), .out_instr(oinstr[0]), .out_pc(opc[0]),
        .out_illegal(ill[0]), .flush_i(flush_i), .drain_i(drain_i), .stall_o(stl[0])
    );

    decode_ctrl_stage #(.PC_W(32), .LOAD_LAT(0), .CSR_EN(0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld[1]), .out_ready(out_ready),
        .out_ctrl(ctrl[1]), .out_instr(oinstr[1]), .out_pc(opc[1]),
        .out_illegal(ill[1]), .flush_i(flush_i), .drain_i(drain_i), .stall_o(stl[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    int          lat    [2];
    bit          csr_en [2];
    bit          m_vld  [2];
    logic [16:0] m_ctrl [2];
    logic [31:0] m_instr[2];
    logic [31:0] m_pc   [2];
    bit          m_ill  [2];
    int          m_mode [2];  // 0 running, 1 waiting on a load, 2 waiting for drain
    logic [4:0]  m_ldrd [2];
    int          m_ldcnt[2];
    bit          e_ready[2];
    bit          e_haz  [2];

    // Bit 17 set means illegal; otherwise [16:0] is the control bundle.
    function automatic logic [17:0] ref_decode(input logic [6:0] op, input bit csr_on);
        int v;
        case (op)
            7'h03:   v = 1 + 32 + 64 + 128 + (1 << 11) + (3 << 13);
            7'h23:   v = 2 + 32 + 256 + (1 << 11) + (2 << 13);
            7'h33:   v = 64;
            7'h13:   v = 1 + 32 + 64;
            7'h37:   v = 3 + 16 + 32 + 64 + (2 << 11) + (1 << 13);
            7'h17:   v = 3 + 16 + 32 + 64 + (1 << 13);
            7'h6f:   v = 1 + 4 + 512 + 32 + 64 + (3 << 11) + (1 << 13);
            7'h67:   v = 1 + 4 + 32 + 64 + (3 << 11) + (1 << 13);
            7'h63:   v = 8 + (5 << 13);
            7'h73:   v = csr_on ? (1024 + 32 + 64 + (2 << 11) + (4 << 13)) : -1;
            7'h0f:   v = 65536 + 32;
            default: v = -1;
        endcase
        if (v < 0) return {1'b1, 17'd0};
        return {1'b0, v[16:0]};
    endfunction

    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        logic [6:0] op;
        bit u1, u2;
        op = w[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        if (r == 5'd0) return 1'b0;
        return (u1 && w[19:15] == r) || (u2 && w[24:20] == r);
    endfunction

    task automatic model_clear(input int k);
        m_vld[k] = 0; m_ctrl[k] = '0; m_instr[k] = '0; m_pc[k] = '0; m_ill[k] = 0;
        m_mode[k] = 0; m_ldrd[k] = '0; m_ldcnt[k] = 0;
    endtask

    task automatic model_eval(input int k);
        bit haz;
        if (!reset) model_clear(k);
        haz = 1'b0;
        if (lat[k] != 0 && in_valid) begin
            if (m_ldcnt[k] != 0 && reads_reg(in_instr, m_ldrd[k])) haz = 1'b1;
            if (m_vld[k] && m_instr[k][6:0] == 7'h03 && reads_reg(in_instr, m_instr[k][11:7]))
                haz = 1'b1;
        end
        e_haz[k]   = haz;
        e_ready[k] = reset && m_mode[k] == 0 && !flush_i && !haz && (!m_vld[k] || out_ready);
    endtask

    task automatic model_update(input int k);
        bit in_x, out_x;
        logic [17:0] d;
        if (!reset) begin
            model_clear(k);
            return;
        end
        in_x  = in_valid && e_ready[k];
        out_x = m_vld[k] && out_ready;
        d     = ref_decode(in_instr[6:0], csr_en[k]);
        if (flush_i) begin
            m_vld[k] = 0; m_ldcnt[k] = 0; m_mode[k] = 0;
            return;
        end
        case (m_mode[k])
            0: if (e_haz[k]) m_mode[k] = 1; else if (in_x && d[16]) m_mode[k] = 2;
            1: if (!e_haz[k]) m_mode[k] = 0;
            default: if (drain_i && !m_vld[k]) m_mode[k] = 0;
        endcase
        if (out_x && m_instr[k][6:0] == 7'h03) begin
            m_ldrd[k]  = m_instr[k][11:7];
            m_ldcnt[k] = lat[k];
        end else if (m_ldcnt[k] > 0) begin
            m_ldcnt[k]--;
        end
        if (in_x) begin
            m_vld[k] = 1; m_ctrl[k] = d[16:0]; m_ill[k] = d[17];
            m_instr[k] = in_instr; m_pc[k] = in_pc;
        end else if (out_x) begin
            m_vld[k] = 0;
        end
    endtask

    task automatic compare(input int k);
        check_eq($sformatf("d%0d.in_ready", k), rdy[k], e_ready[k]);
        check_eq($sformatf("d%0d.out_valid", k), vld[k], m_vld[k]);
        check_eq($sformatf("d%0d.out_ctrl", k), ctrl[k], m_ctrl[k]);
        check_eq($sformatf("d%0d.out_instr", k), oinstr[k], m_instr[k]);
        check_eq($sformatf("d%0d.out_pc", k), opc[k], m_pc[k]);
        check_eq($sformatf("d%0d.out_illegal", k), ill[k], m_ill[k]);
        check_eq($sformatf("d%0d.stall_o", k), stl[k], m_mode[k] != 0);
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        #1;
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            compare(k);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input bit ordy, input bit fl,
                         input bit dr);
        in_valid  = v;
        in_instr  = w;
        in_pc     = $urandom();
        out_ready = ordy;
        flush_i   = fl;
        drain_i   = dr;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom();
        case ($urandom_range(0, 12))
            0, 11:   op = 7'h03;
            1:       op = 7'h23;
            2:       op = 7'h33;
            3:       op = 7'h13;
            4:       op = 7'h37;
            5:       op = 7'h17;
            6:       op = 7'h6f;
            7:       op = 7'h67;
            8:       op = 7'h63;
            9:       op = 7'h73;
            10:      op = 7'h0f;
            default: op = w[6:0];
        endcase
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // ---------------------------------------------------------------- stimulus
    bit acc [2];
    bit seen [2];
    int waited [2];

    initial begin
        lat[0] = 1; lat[1] = 0; csr_en[0] = 1; csr_en[1] = 0;
        for (int k = 0; k < 2; k++) model_clear(k);

        // Reset with in_valid high
        reset = 1'b0;
        drive(1, I_ADDI, 1, 0, 1);
        @(negedge clk); #1;
        check_eq("rst.in_ready", rdy[0], 1'b0);
        check_eq("rst.out_valid", vld[0], 1'b0);
        check_eq("rst.out_ctrl", ctrl[0], 17'd0);
        check_eq("rst.stall_o", stl[0], 1'b0);
        cycle();
        reset = 1'b1;
        #1;
        check_eq("rel.in_ready0", rdy[0], 1'b1);
        check_eq("rel.in_ready1", rdy[1], 1'b1);
        cycle();
        check_eq("addi.out_valid", vld[0], 1'b1);
        check_eq("addi.out_ctrl", ctrl[0], 17'h00061);

        // Load-use: dependent ADD held on the interlocked instance only
        drive(1, I_LW_X5, 1, 0, 1);
        cycle();
        drive(1, I_ADD, 1, 0, 1);
        for (int k = 0; k < 2; k++) begin acc[k] = 0; seen[k] = 0; waited[k] = 0; end
        for (int i = 0; i < 8; i++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!acc[k] && rdy[k]) begin acc[k] = 1; waited[k] = i; end
                if (stl[k]) seen[k] = 1;
            end
            cycle();
        end
        check_eq("lu.d0.accepted", acc[0], 1'b1);
        check_eq("lu.d0.held", waited[0] > 0, 1'b1);
        check_eq("lu.d0.stall_seen", seen[0], 1'b1);
        check_eq("lu.d1.held_cycles", waited[1], 0);
        check_eq("lu.d1.stall_seen", seen[1], 1'b0);

        // Load to x0 never interlocks
        drive(1, I_LW_X0, 1, 0, 1);
        cycle();
        drive(1, I_ADD_X0, 1, 0, 1);
        #1;
        check_eq("x0.in_ready", rdy[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("x0.stall_o", stl[0], 1'b0);
        end

        // Back-pressure: output held stable, input blocked
        drive(0, 32'd0, 1, 0, 1);
        cycle();
        drive(1, I_ADDI, 0, 0, 1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, I_BAD, 0, 0, 1);
            #1;
            check_eq("bp.in_ready", rdy[0], 1'b0);
            cycle();
            check_eq("bp.out_valid", vld[0], 1'b1);
            check_eq("bp.out_instr", oinstr[0], I_ADDI);
            check_eq("bp.out_ctrl", ctrl[0], 17'h00061);
        end

        // FENCE waits for drain and an empty output
        drive(0, 32'd0, 1, 0, 1);
        cycle();
        drive(1, I_FENCE, 1, 0, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1, I_ADDI, 1, 0, 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("fence.d%0d.in_ready", k), rdy[k], 1'b0);
                check_eq($sformatf("fence.d%0d.stall_o", k), stl[k], 1'b1);
            end
            cycle();
        end
        drive(0, 32'd0, 1, 0, 1);
        cycle();
        check_eq("fence.d0.released", stl[0], 1'b0);
        check_eq("fence.d1.released", stl[1], 1'b0);

        // Flush during a load stall with the load still held
        drive(1, I_LW_X5, 0, 0, 1);
        cycle();
        drive(1, I_ADD, 0, 0, 1);
        cycle();
        check_eq("fl.pre.stall_o", stl[0], 1'b1);
        check_eq("fl.pre.out_valid", vld[0], 1'b1);
        drive(1, I_ADD, 0, 1, 1);
        #1;
        check_eq("fl.in_ready", rdy[0], 1'b0);
        cycle();
        check_eq("fl.out_valid0", vld[0], 1'b0);
        check_eq("fl.stall_o", stl[0], 1'b0);
        check_eq("fl.out_valid1", vld[1], 1'b0);
        drive(0, 32'd0, 1, 0, 1);
        cycle();

        // Illegal opcode, and SYSTEM with and without CSR support
        drive(1, I_BAD, 1, 0, 1);
        cycle();
        check_eq("ill.out_illegal", ill[0], 1'b1);
        check_eq("ill.out_ctrl", ctrl[0], 17'd0);
        drive(1, I_CSR, 1, 0, 1);
        cycle();
        check_eq("csr.d0.out_illegal", ill[0], 1'b0);
        check_eq("csr.d0.out_ctrl", ctrl[0], 17'h09460);
        check_eq("csr.d1.out_illegal", ill[1], 1'b1);
        check_eq("csr.d1.out_ctrl", ctrl[1], 17'd0);

        // Reset in the middle of a fence wait drops everything
        drive(1, I_FENCE, 1, 0, 0);
        cycle();
        check_eq("rf.stall_o", stl[0], 1'b1);
        reset = 1'b0;
        drive(0, 32'd0, 1, 0, 0);
        #1;
        check_eq("rf.rst.stall_o", stl[0], 1'b0);
        check_eq("rf.rst.out_valid", vld[0], 1'b0);
        check_eq("rf.rst.out_ctrl", ctrl[0], 17'd0);
        cycle();
        reset = 1'b1;
        #1;
        check_eq("rf.rel.in_ready", rdy[0], 1'b1);
        cycle();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
